memory_responder: RTL and testbench
===================================

# memory_responder

Memory-side responder for the CPU's memory request interface: it accepts the read and write strobes, address and write data driven by the control unit and datapath. Each request is serviced after a configurable number of wait states, then completion is signalled with a one-cycle `ready` pulse. It sits between the CPU bus (address from AR, write data from the common bus) and a single-port RAM array. It replaces an always-ready combinational memory so the sequencer can be exercised against realistic latency.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: address width; depth is 2**ADDR_WIDTH words.
- `DATA_WIDTH`, 8: word width.
- `WAIT_STATES`, 1: idle cycles inserted before each access commits; legal range 0..15.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  ADDR_WIDTH  request address, sampled when a request is accepted.
- `write_data`  in  DATA_WIDTH  write data, sampled when a request is accepted.
- `memory_read`  in  1  read request strobe (level).
- `memory_write`  in  1  write request strobe (level); has priority over `memory_read`.
- `read_data`  out  DATA_WIDTH  registered read result; holds its value until the next read completes.
- `ready`  out  1  one-cycle completion pulse for both reads and writes.
- `busy`  out  1  high while a request is latched and not yet completed.
- `dbg_address`  in  ADDR_WIDTH  bench-only peek address.
- `dbg_data`  out  DATA_WIDTH  combinational array contents at `dbg_address`; no side effects.

## Operation
- FSM states:
  - IDLE: no request held.
  - WAIT: counting wait states.
  - RESPOND: access commits, `ready` is driven high.
- IDLE, on a clock edge:
  - If `memory_write`=1, latch op=WRITE, `address`, `write_data`.
  - Else if `memory_read`=1, latch op=READ, `address`.
  - On either latch, load the wait counter with `WAIT_STATES`. Go to WAIT if `WAIT_STATES`>0, else go to RESPOND.
  - With no strobe, stay in IDLE.
- WAIT: decrement the counter each edge. When the counter reaches 1, go to RESPOND on that edge.
- Access commit (on the edge entering RESPOND):
  - READ loads `read_data` from array[latched address].
  - WRITE stores the latched data to array[latched address]; `read_data` is unchanged.
- RESPOND: `ready`=1 for exactly this cycle. Next edge goes to IDLE unconditionally. A strobe seen in RESPOND is not accepted.
- `busy`=1 in WAIT and RESPOND, 0 in IDLE.
- Strobe changes after acceptance are ignored; there is no queue and no abort.
- Both strobes high: treated as a write only. The control unit's default-high read strobe must not cause a second access.
- Back-to-back: a strobe held continuously is re-accepted in the IDLE cycle after RESPOND. Each request therefore occupies WAIT_STATES+2 cycles.
- Addresses use the full ADDR_WIDTH, so there is no out-of-range case. Address all-ones is a normal location.

## Timing
- Reset values: state IDLE, `ready`=0, `busy`=0, `read_data`=0, wait counter 0, latched op/address/data 0.
- Reset does not clear the RAM array.
- Latency: request accepted at edge k gives `ready` high during the cycle after edge k+WAIT_STATES.
  - WAIT_STATES=0: `ready` one cycle after acceptance.
  - WAIT_STATES=1: `ready` two cycles after acceptance.
- `read_data` becomes valid in the same cycle `ready` rises.
- Reset asserted in WAIT: the request is dropped, no write occurs, and `read_data` is forced to 0.
- Reset asserted on the edge that would commit: reset wins; no write, and `ready` stays 0.
- Reset asserted during RESPOND: the write has already committed and persists.
- Write followed by a read of the same address returns the new data.
- `dbg_data` reflects a write starting the cycle after the committing edge.
- No combinational path from the inputs to `ready`, `busy` or `read_data`.

## Structure
- Shared package `memory_pkg` holds:
  - the state enum {IDLE, WAIT, RESPOND};
  - the op encoding (READ=0, WRITE=1);
  - localparam for the wait-counter width (4 bits).
- Sub-module `memory_array`:
  - synchronous-write, asynchronous-read RAM;
  - parameters ADDR_WIDTH and DATA_WIDTH;
  - ports: clock, we, waddr, wdata, raddr, rdata, plus a second async read port for `dbg_address`.
- `memory_responder` holds the FSM, wait counter, request latches and the `read_data` register.

## Test plan
- Reset, then WAIT_STATES=1, write 0x3C to address 0x05: `busy` for 2 cycles, `ready` pulses 2 cycles after acceptance, `dbg_data`@0x05 = 0x3C, `read_data` stays 0x00.
- Read 0x05 with WAIT_STATES=0: `ready` one cycle after acceptance with `read_data`=0x3C. Then write 0xFF to 0xFF and read it back: 0xFF at address 0xFF.
- `memory_read`=`memory_write`=1, address 0x10, data 0xA5: exactly one write occurs, array[0x10]=0xA5, `read_data` unchanged, one `ready` pulse.
- `memory_read` held high for 8 cycles with WAIT_STATES=1: `ready` pulses every 3 cycles, and address changes mid-request do not affect the in-flight read.
- Write 0x77 to 0x20 with WAIT_STATES=3, `reset` asserted in the second WAIT cycle: array[0x20] keeps its old value, `ready` never pulses, and all outputs return to reset values on the next edge.
- Assert `reset` during RESPOND of a write of 0x11 to 0x30: array[0x30]=0x11 and the FSM is in IDLE after the edge.

Source files
------------

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and constants for the memory responder
package memory_pkg;

    localparam int WAIT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/memory_array.sv
// rtl/memory_array.sv - synchronous-write, asynchronous-read RAM with a debug read port
module memory_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [ADDR_WIDTH-1:0] dbg_raddr,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata     = mem[raddr];
    assign dbg_rdata = mem[dbg_raddr];

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - memory request responder with configurable wait states
module memory_responder
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH           = 8,
    parameter int DATA_WIDTH           = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  memory_read,
    input  logic                  memory_write,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] dbg_address,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(1);

    state_t                    state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    op_t                       op_q, op_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;

    logic                  in_idle;
    logic                  accept;
    logic                  commit;
    op_t                   acc_op;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  array_we;

    // With zero wait states the access commits on the accepting edge, so the
    // array is driven straight from the request inputs while idle.
    assign in_idle  = (state_q == IDLE);
    assign accept   = in_idle && (memory_write || memory_read);
    assign acc_op   = in_idle ? (memory_write ? WRITE : READ) : op_q;
    assign acc_addr = in_idle ? address : addr_q;
    assign acc_data = in_idle ? write_data : data_q;
    assign commit   = (accept && (WAIT_STATES == 0))
                   || ((state_q == WAIT) && (cnt_q == WAIT_LAST));
    assign array_we = commit && (acc_op == WRITE) && !reset;

    memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clock     (clock),
        .we        (array_we),
        .waddr     (acc_addr),
        .wdata     (acc_data),
        .raddr     (acc_addr),
        .rdata     (rd_word),
        .dbg_raddr (dbg_address),
        .dbg_rdata (dbg_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = acc_op;
                    addr_d = address;
                    data_d = memory_write ? write_data : data_q;
                    cnt_d  = WAIT_LOAD;
                    state_d = (WAIT_STATES > 0) ? WAIT : RESPOND;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - WAIT_LAST;
                if (cnt_q == WAIT_LAST) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit && (acc_op == READ)) begin
            read_data_d = rd_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= READ;
            addr_q      <= '0;
            data_q      <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;
    assign ready     = (state_q == RESPOND);
    assign busy      = !in_idle;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - scoreboard bench for memory_responder at 0, 1 and 3 wait states
module tb_memory_responder;

    typedef struct {
        int         dut;
        int         cyc;
        logic [7:0] data;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst  [3];
    logic       rd   [3];
    logic       wr   [3];
    logic [7:0] addr [3];
    logic [7:0] wdat [3];
    logic [7:0] dbga [3];
    logic [7:0] rdat [3];
    logic [7:0] dbgd [3];
    logic       rdy  [3];
    logic       bsy  [3];

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(rst[0]), .address(addr[0]), .write_data(wdat[0]),
        .memory_read(rd[0]), .memory_write(wr[0]), .read_data(rdat[0]),
        .ready(rdy[0]), .busy(bsy[0]), .dbg_address(dbga[0]), .dbg_data(dbgd[0])
    );
    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(1)) u_ws1 (
        .clock(clock), .reset(rst[1]), .address(addr[1]), .write_data(wdat[1]),
        .memory_read(rd[1]), .memory_write(wr[1]), .read_data(rdat[1]),
        .ready(rdy[1]), .busy(bsy[1]), .dbg_address(dbga[1]), .dbg_data(dbgd[1])
    );
    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset(rst[2]), .address(addr[2]), .write_data(wdat[2]),
        .memory_read(rd[2]), .memory_write(wr[2]), .read_data(rdat[2]),
        .ready(rdy[2]), .busy(bsy[2]), .dbg_address(dbga[2]), .dbg_data(dbgd[2])
    );

    function automatic int ws_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic check(string name, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(int d, int at, logic [7:0] data);
        exp_t e;
        e.dut  = d;
        e.cyc  = at;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                if (rdy[d]) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_ready dut=%0d cyc=%0d got ready=1 exp none", d, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.dut != d || e.cyc != cyc || rdat[d] !== e.data) begin
                            bad++;
                            $display("FAIL ready_resp got dut=%0d cyc=%0d data=%h exp dut=%0d cyc=%0d data=%h",
                                     d, cyc, rdat[d], e.dut, e.cyc, e.data);
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_op(int d, logic w, logic r, logic [7:0] a, logic [7:0] wd, logic [7:0] exp_rd);
        @(negedge clock);
        wr[d] = w; rd[d] = r; addr[d] = a; wdat[d] = wd;
        push(d, cyc + 1 + ws_of(d), exp_rd);
        @(negedge clock);
        wr[d] = 1'b0; rd[d] = 1'b0; addr[d] = ~a; wdat[d] = ~wd;
        repeat (ws_of(d) + 1) @(negedge clock);
    endtask

    task automatic peek(string name, int d, logic [7:0] a, logic [7:0] exp);
        dbga[d] = a;
        #1;
        check(name, dbgd[d], exp);
    endtask

    initial begin
        int c;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = 8'h00; wdat[d] = 8'h00; dbga[d] = 8'h00;
        end
        fork
            monitor();
        join_none

        repeat (2) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            check("reset_ready", {7'd0, rdy[d]}, 8'h00);
            check("reset_busy", {7'd0, bsy[d]}, 8'h00);
            check("reset_read_data", rdat[d], 8'h00);
        end
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // WS=1 write with busy profile
        @(negedge clock);
        wr[1] = 1'b1; addr[1] = 8'h05; wdat[1] = 8'h3C;
        push(1, cyc + 2, 8'h00);
        @(negedge clock);
        wr[1] = 1'b0; addr[1] = 8'hAA; wdat[1] = 8'h55;
        check("t1_busy_wait", {7'd0, bsy[1]}, 8'h01);
        @(negedge clock);
        check("t1_busy_respond", {7'd0, bsy[1]}, 8'h01);
        @(negedge clock);
        check("t1_busy_idle", {7'd0, bsy[1]}, 8'h00);
        peek("t1_dbg_05", 1, 8'h05, 8'h3C);
        check("t1_read_data_held", rdat[1], 8'h00);

        // WS=0 write/read and the all-ones address
        do_op(0, 1'b1, 1'b0, 8'h05, 8'h3C, 8'h00);
        do_op(0, 1'b0, 1'b1, 8'h05, 8'h00, 8'h3C);
        do_op(0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h3C);
        do_op(0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF);
        peek("t2_dbg_ff", 0, 8'hFF, 8'hFF);

        // Both strobes: write only, read_data untouched
        do_op(1, 1'b0, 1'b1, 8'h05, 8'h00, 8'h3C);
        do_op(1, 1'b1, 1'b1, 8'h10, 8'hA5, 8'h3C);
        peek("t3_dbg_10", 1, 8'h10, 8'hA5);
        check("t3_read_data_kept", rdat[1], 8'h3C);

        // Read strobe held 8 cycles, address moving mid-request
        @(negedge clock);
        c = cyc;
        rd[1] = 1'b1; addr[1] = 8'h05;
        push(1, c + 2, 8'h3C);
        push(1, c + 5, 8'hA5);
        push(1, c + 8, 8'h3C);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (i == 1) addr[1] = 8'h10;
            if (i == 4) addr[1] = 8'h05;
        end
        rd[1] = 1'b0;
        repeat (3) @(negedge clock);

        // Reset during RESPOND of a write: write persists
        @(negedge clock);
        wr[1] = 1'b1; addr[1] = 8'h30; wdat[1] = 8'h11;
        push(1, cyc + 2, 8'h3C);
        @(negedge clock);
        wr[1] = 1'b0;
        @(negedge clock);
        rst[1] = 1'b1;
        @(negedge clock);
        rst[1] = 1'b0;
        check("t5_busy_after_reset", {7'd0, bsy[1]}, 8'h00);
        check("t5_read_data_reset", rdat[1], 8'h00);
        peek("t5_dbg_30", 1, 8'h30, 8'h11);

        // WS=3: reset in the second WAIT cycle drops the write
        do_op(2, 1'b1, 1'b0, 8'h20, 8'h42, 8'h00);
        do_op(2, 1'b0, 1'b1, 8'h20, 8'h00, 8'h42);
        @(negedge clock);
        wr[2] = 1'b1; addr[2] = 8'h20; wdat[2] = 8'h77;
        @(negedge clock);
        wr[2] = 1'b0;
        check("t4_busy_wait", {7'd0, bsy[2]}, 8'h01);
        @(negedge clock);
        rst[2] = 1'b1;
        @(negedge clock);
        rst[2] = 1'b0;
        check("t4_ready_reset", {7'd0, rdy[2]}, 8'h00);
        check("t4_busy_reset", {7'd0, bsy[2]}, 8'h00);
        check("t4_read_data_reset", rdat[2], 8'h00);
        repeat (5) @(negedge clock);
        peek("t4_dbg_20", 2, 8'h20, 8'h42);

        repeat (4) @(negedge clock);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL missing_ready got pending=%0d exp 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
